// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states, slice width and
// the operand width legality check.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int NIBBLE_W = 4;

  // Operand width must be a whole, non-zero number of nibbles.
  function automatic bit width_ok(input int w);
    return (w % NIBBLE_W == 0) && (w >= NIBBLE_W);
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple adder slice with carry-in; ovf is the carry into
// bit 3 XOR the carry out of bit 3.
module nibble_adder
  import adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                ovf
);

  logic [NIBBLE_W:0] w_c;

  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end
  end

  assign cout = w_c[NIBBLE_W];
  assign ovf  = w_c[NIBBLE_W-1] ^ w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder built by stepping one 4-bit ripple slice across the operands,
// one nibble per clock, with valid/ready handshakes on both sides.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end

  state_t                         r_state, w_next;
  logic [NIB-1:0][NIBBLE_W-1:0]   r_a, r_b, r_sum;
  logic [KW-1:0]                  r_k;
  logic                           r_carry, r_carryout, r_overflow;
  logic                           r_in_ready, r_out_valid;
  logic                           w_accept, w_step, w_last;
  logic [NIBBLE_W-1:0]            w_s;
  logic                           w_cout, w_ovf;

  nibble_adder u_slice (
    .a    (r_a[r_k]),
    .b    (r_b[r_k]),
    .cin  (r_carry),
    .sum  (w_s),
    .cout (w_cout),
    .ovf  (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid && r_in_ready) w_next = RUN;
      RUN:     if (w_last)                 w_next = DONE;
      DONE:    if (out_ready)              w_next = IDLE;
      default:                             w_next = IDLE;
    endcase
  end

  always_comb begin
    w_accept = (r_state == IDLE) && in_valid && r_in_ready;
    w_step   = (r_state == RUN);
    w_last   = (r_k == KW'(NIB - 1));
  end

  // Handshake flags are registered off the next state so they change on the
  // same edge as the transition that causes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_k         <= '0;
      r_carry     <= 1'b0;
      r_carryout  <= 1'b0;
      r_overflow  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == IDLE);
      r_out_valid <= (w_next == DONE);
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_k     <= '0;
        r_sum   <= '0;
      end else if (w_step) begin
        r_sum[r_k] <= w_s;
        r_carry    <= w_cout;
        r_k        <= w_last ? '0 : r_k + 1'b1;
        if (w_last) begin
          r_carryout <= w_cout;
          r_overflow <= w_ovf;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carryout  = r_carryout;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench: 16-bit and 4-bit builds, handshake timing, backpressure and
// asynchronous reset abort, all against hand-computed results.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, carryout, overflow;
  logic [15:0] a, b, sum;

  logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, carryout4, overflow4;
  logic [3:0]  a4, b4, sum4;

  int checks   = 0;
  int failures = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carryout(carryout), .overflow(overflow)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .carryout(carryout4), .overflow(overflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Accepts one operand pair and checks the 4-edge latency and final result.
  task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                    input logic tc, input logic [15:0] es, input logic eco, input logic eov);
    wait_ready();
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = ~tc;
    chk({tag, "_acc_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_acc_valid"}, 32'(out_valid), 32'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk({tag, "_run_valid"}, 32'(out_valid), 32'd0);
    end
    step();
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_carryout"}, 32'(carryout), 32'(eco));
    chk({tag, "_overflow"}, 32'(overflow), 32'(eov));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_flags", {30'd0, carryout, overflow}, 32'd0);
    #10 rst_n = 1'b1;
    chk("rel_in_ready_low", 32'(in_ready), 32'd0);
    step();
    chk("rel_in_ready_high", 32'(in_ready), 32'd1);

    op("p1", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    release_out("p1");
    op("ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    release_out("ovf");
    op("cin", 16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0);
    release_out("cin");
    op("ffff", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0);
    release_out("ffff");
    op("8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    release_out("8000");

    // Backpressure: DONE holds while inputs churn.
    out_ready = 1'b0;
    op("bp", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      a = 16'(16'h0F0F << i); b = 16'(16'hF0F0 >> i); in_valid = ~in_valid; cin = ~cin;
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_sum", 32'(sum), 32'h3333);
      chk("bp_hold_flags", {30'd0, carryout, overflow}, 32'd0);
    end
    in_valid = 1'b0;
    release_out("bp");
    step();
    chk("bp_single_xfer", 32'(out_valid), 32'd0);

    // Asynchronous reset after the second RUN edge aborts the operation.
    wait_ready();
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("abort_partial_sum", 32'(sum), 32'h00FF);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_flags", {30'd0, carryout, overflow}, 32'd0);
    #1 rst_n = 1'b1;
    #1;
    chk("abort_rel_ready_low", 32'(in_ready), 32'd0);
    step();
    chk("abort_rel_ready_high", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_emit", 32'(out_valid), 32'd0);
    end
    op("post", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    release_out("post");

    // WIDTH=4 build: a single RUN cycle.
    chk("w4_ready", 32'(in_ready4), 32'd1);
    a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0; in_valid4 = 1'b1;
    step();
    in_valid4 = 1'b0;
    chk("w4_acc_valid", 32'(out_valid4), 32'd0);
    chk("w4_acc_ready", 32'(in_ready4), 32'd0);
    step();
    chk("w4_out_valid", 32'(out_valid4), 32'd1);
    chk("w4_sum", 32'(sum4), 32'h8);
    chk("w4_overflow", 32'(overflow4), 32'd1);
    chk("w4_carryout", 32'(carryout4), 32'd0);
    step();
    chk("w4_rel_valid", 32'(out_valid4), 32'd0);
    chk("w4_rel_ready", 32'(in_ready4), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
